i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target with a byte-wide register file, auto-incrementing pointer and host read port.
// Optional SCL/SDA 3-sample majority glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target #(
  parameter logic [6:0] DEVICE_ADDR = 7'h3C,
  parameter int         REG_COUNT   = 16,
  localparam int        AW          = $clog2(REG_COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_e;

  // Bit 1 carries SCL, bit 0 carries SDA through every line-conditioning stage.
  logic [1:0] sync1_q, sync2_q, lines_f, prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {scl_in, sda_in};
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] hist0_q, hist1_q, hist2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist0_q <= 2'b11;
      hist1_q <= 2'b11;
      hist2_q <= 2'b11;
    end else begin
      hist0_q <= sync2_q;
      hist1_q <= hist0_q;
      hist2_q <= hist1_q;
    end
  end

  assign lines_f = (hist0_q & hist1_q) | (hist0_q & hist2_q) | (hist1_q & hist2_q);
`else
  assign lines_f = sync2_q;
`endif

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

  assign scl_f     = lines_f[1];
  assign sda_f     = lines_f[0];
  assign scl_rise  = scl_f & ~prev_q[1];
  assign scl_fall  = ~scl_f & prev_q[1];
  assign start_det = scl_f & prev_q[1] & prev_q[0] & ~sda_f;
  assign stop_det  = scl_f & prev_q[1] & ~prev_q[0] & sda_f;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d, byte_in;
  logic [AW-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [7:0]    regs_q [REG_COUNT];

  assign byte_in = {shift_q[6:0], sda_f};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      busy_d   = 1'b1;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = 4'd0;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              case (state_q)
                ADDR: state_d = (shift_q[6:0] == DEVICE_ADDR) ? ADDR_ACK : WAIT_STOP;
                PTR: begin
                  ptr_d   = byte_in[AW-1:0];
                  state_d = PTR_ACK;
                end
                default: begin
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = ptr_q;
                  wr_data_d   = byte_in;
                  ptr_d       = ptr_q + AW'(1);
                  state_d     = WDATA_ACK;
                end
              endcase
            end
          end
        end
        // First SCL fall after the 8th bit pulls SDA; the next fall releases it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              if (state_q == ADDR_ACK && shift_q[0]) begin
                state_d  = RDATA;
                shift_d  = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = RDATA_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        // cnt=9 marks an initiator ACK awaiting the fall that starts the next byte.
        RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              ptr_d = ptr_q + AW'(1);
              cnt_d = 4'd9;
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && cnt_q == 4'd9) begin
            state_d  = RDATA;
            cnt_d    = 4'd0;
            shift_d  = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][7];
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q      <= 2'b11;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 8'h00;
    end else begin
      prev_q      <= lines_f;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      if (wr_strobe_d) regs_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = regs_q[host_addr];

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged initiator, open-drain SDA model, strobe logger.
module tb_i2c_target;
  localparam int T = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_tb = 1'b1;
  logic       sda_tb = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [3:0] host_addr = 4'd0;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int checks = 0;
  int failures = 0;

  assign sda_line = sda_tb & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk(clk), .reset(reset), .scl_in(scl_tb), .sda_in(sda_line), .sda_oe(sda_oe),
    .host_addr(host_addr), .host_rdata(host_rdata), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  // Strobe log and SDA-drive counter, sampled on the inactive clock edge.
  logic [11:0] strobe_log [256];
  int strobe_cnt = 0;
  int oe_cnt = 0;
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_log[strobe_cnt[7:0]] <= {wr_addr, wr_data};
      strobe_cnt <= strobe_cnt + 1;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  typedef struct {
    logic [7:0] ptr_byte;
    logic [7:0] data;
    logic [3:0] exp_addr;
  } wvec_t;
  wvec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (scl_tb == 1'b0) begin
      sda_tb = 1'b1; tick(T);
      scl_tb = 1'b1; tick(T);
    end
    sda_tb = 1'b0; tick(T);
    scl_tb = 1'b0; tick(4);
  endtask

  task automatic i2c_stop();
    scl_tb = 1'b0; tick(4);
    sda_tb = 1'b0; tick(T);
    scl_tb = 1'b1; tick(T);
    sda_tb = 1'b1; tick(T);
  endtask

  // glitch_bit >= 0 inserts a 1-clk SCL high pulse in that bit's low phase.
  task automatic write_bit(input logic b, input bit glitch);
    sda_tb = b;
    if (glitch) begin
      tick(T / 2); scl_tb = 1'b1;
      tick(1);     scl_tb = 1'b0;
      tick(T / 2);
    end else begin
      tick(T);
    end
    scl_tb = 1'b1; tick(T);
    scl_tb = 1'b0; tick(4);
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic acked);
    for (int i = 7; i >= 0; i--) write_bit(b[i], i == glitch_bit);
    sda_tb = 1'b1; tick(T);
    scl_tb = 1'b1; tick(T / 2);
    acked = ~sda_line;
    tick(T / 2);
    scl_tb = 1'b0; tick(4);
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] d);
    sda_tb = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(T);
      scl_tb = 1'b1; tick(T / 2);
      d[i] = sda_line;
      tick(T / 2);
      scl_tb = 1'b0; tick(4);
    end
    sda_tb = ~send_ack; tick(T);
    scl_tb = 1'b1; tick(T);
    scl_tb = 1'b0; tick(4);
    sda_tb = 1'b1;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    host_addr = a;
    tick(1);
    d = host_rdata;
  endtask

  logic       ack;
  logic [7:0] rd;
  int         s0;
  int         o0;
  int         nonzero;
  bit         seen;

  initial begin
    vecs[0] = '{ptr_byte: 8'h13, data: 8'h3C, exp_addr: 4'd3};
    vecs[1] = '{ptr_byte: 8'hFF, data: 8'h81, exp_addr: 4'd15};
    vecs[2] = '{ptr_byte: 8'h00, data: 8'h7E, exp_addr: 4'd0};
    vecs[3] = '{ptr_byte: 8'h04, data: 8'hC3, exp_addr: 4'd4};
    vecs[4] = '{ptr_byte: 8'h2A, data: 8'h66, exp_addr: 4'd10};

    tick(3);
    reset = 1'b0;
    tick(2);
    check("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("reset_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("reset_wr_data", {24'd0, wr_data}, 32'd0);
    host_read(4'd9, rd);
    check("reset_reg9", {24'd0, rd}, 32'd0);

    // Two-byte burst write with pointer auto-increment.
    s0 = strobe_cnt;
    i2c_start();
    check("burst_busy", {31'd0, busy}, 32'd1);
    write_byte(8'h78, -1, ack); check("burst_ack_addr", {31'd0, ack}, 32'd1);
    write_byte(8'h02, -1, ack); check("burst_ack_ptr", {31'd0, ack}, 32'd1);
    write_byte(8'hA5, -1, ack); check("burst_ack_d0", {31'd0, ack}, 32'd1);
    write_byte(8'h5A, -1, ack); check("burst_ack_d1", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("burst_busy_after_stop", {31'd0, busy}, 32'd0);
    check("burst_strobe_count", strobe_cnt - s0, 32'd2);
    check("burst_strobe0", {20'd0, strobe_log[s0[7:0]]}, {20'd0, 4'd2, 8'hA5});
    check("burst_strobe1", {20'd0, strobe_log[s0[7:0] + 8'd1]}, {20'd0, 4'd3, 8'h5A});
    host_read(4'd3, rd); check("burst_host_reg3", {24'd0, rd}, 32'h5A);
    host_read(4'd2, rd); check("burst_host_reg2", {24'd0, rd}, 32'hA5);
    $display("txn burst_write ptr=2 data=a5,5a strobes=%0d", strobe_cnt - s0);

    for (int v = 0; v < 5; v++) begin
      s0 = strobe_cnt;
      i2c_start();
      write_byte(8'h78, -1, ack);             check("vec_ack_addr", {31'd0, ack}, 32'd1);
      write_byte(vecs[v].ptr_byte, -1, ack);  check("vec_ack_ptr", {31'd0, ack}, 32'd1);
      write_byte(vecs[v].data, -1, ack);      check("vec_ack_data", {31'd0, ack}, 32'd1);
      i2c_stop();
      check("vec_strobe_count", strobe_cnt - s0, 32'd1);
      check("vec_strobe", {20'd0, strobe_log[s0[7:0]]}, {20'd0, vecs[v].exp_addr, vecs[v].data});
      host_read(vecs[v].exp_addr, rd);
      check("vec_host_read", {24'd0, rd}, {24'd0, vecs[v].data});
      $display("txn vec%0d ptr_byte=%02h data=%02h read_back=%02h", v, vecs[v].ptr_byte, vecs[v].data, rd);
    end

    // Pointer-only write to 15, then a two-byte read that wraps to register 0.
    i2c_start();
    write_byte(8'h78, -1, ack); write_byte(8'h0F, -1, ack);
    i2c_stop();
    i2c_start();
    write_byte(8'h79, -1, ack); check("wrap_ack_addr", {31'd0, ack}, 32'd1);
    read_byte(1'b1, rd); check("wrap_rd15", {24'd0, rd}, 32'h81);
    read_byte(1'b0, rd); check("wrap_rd0", {24'd0, rd}, 32'h7E);
    check("wrap_busy_before_stop", {31'd0, busy}, 32'd1);
    i2c_stop();
    check("wrap_busy_after_stop", {31'd0, busy}, 32'd0);
    $display("txn read_wrap reg15 then reg0");

    // Foreign address: no ACK, no drive, no writes.
    s0 = strobe_cnt;
    o0 = oe_cnt;
    i2c_start();
    write_byte(8'h7A, -1, ack); check("foreign_nack_addr", {31'd0, ack}, 32'd0);
    write_byte(8'h01, -1, ack);
    write_byte(8'h22, -1, ack);
    write_byte(8'h33, -1, ack);
    i2c_stop();
    check("foreign_no_drive", oe_cnt - o0, 32'd0);
    check("foreign_no_strobe", strobe_cnt - s0, 32'd0);
    $display("txn foreign_addr 0x7a ignored");

    // Repeated START four bits into a data byte discards it.
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h78, -1, ack); write_byte(8'h04, -1, ack);
    for (int i = 0; i < 4; i++) write_bit(1'b0, 1'b0);
    i2c_start();
    write_byte(8'h79, -1, ack); check("rs_ack_addr", {31'd0, ack}, 32'd1);
    read_byte(1'b0, rd);
    i2c_stop();
    check("rs_read_reg4", {24'd0, rd}, 32'hC3);
    check("rs_no_strobe", strobe_cnt - s0, 32'd0);
    $display("txn repeated_start_mid_byte read=%02h", rd);

    // Pointer persists into a fresh read transaction.
    i2c_start();
    write_byte(8'h79, -1, ack);
    read_byte(1'b0, rd);
    i2c_stop();
    check("persist_read_reg4", {24'd0, rd}, 32'hC3);
    $display("txn pointer_persist read=%02h", rd);

    // Reset while the target is ACKing the pointer byte.
    i2c_start();
    write_byte(8'h78, -1, ack);
    for (int i = 7; i >= 0; i--) write_bit(rd[i] ^ rd[i] ^ (i == 0 || i == 2), 1'b0);
    sda_tb = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick(1);
      seen = sda_oe;
    end
    check("rst_ack_seen", {31'd0, seen}, 32'd1);
    reset = 1'b1; tick(1);
    reset = 1'b0;
    check("rst_sda_released", {31'd0, sda_oe}, 32'd0);
    scl_tb = 1'b1; tick(T);
    i2c_stop();
    nonzero = 0;
    for (int a = 0; a < 16; a++) begin
      host_read(a[3:0], rd);
      if (rd != 8'h00) nonzero++;
    end
    check("rst_regs_cleared", nonzero, 32'd0);
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h78, -1, ack); check("rst_after_ack_addr", {31'd0, ack}, 32'd1);
    write_byte(8'h06, -1, ack); check("rst_after_ack_ptr", {31'd0, ack}, 32'd1);
    write_byte(8'h99, -1, ack); check("rst_after_ack_data", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("rst_after_strobe", {20'd0, strobe_log[s0[7:0]]}, {20'd0, 4'd6, 8'h99});
    host_read(4'd6, rd); check("rst_after_read", {24'd0, rd}, 32'h99);
    $display("txn reset_during_ack then write reg6=%02h", rd);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h78, -1, ack);
    write_byte(8'h07, 2, ack);  check("glitch_ack_ptr", {31'd0, ack}, 32'd1);
    write_byte(8'h5C, 5, ack);  check("glitch_ack_data", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("glitch_strobe", {20'd0, strobe_log[s0[7:0]]}, {20'd0, 4'd7, 8'h5C});
    $display("txn glitch_filtered write reg7");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
